adc_multi_channel_if: RTL and testbench

Next-generation ADC front end for the scope acquisition path. It drives NCH parallel ADC1175-class converters from one divided clock and captures all channels on a single internal strobe. It discards the converter pipeline latency, then optionally reduces the data: pass-through, block average, or block peak. Results are buffered in a small FIFO behind the simple interface (SI_data/SI_rdy/SI_ack). Overflow detection is sticky and clearable.

---
 rtl/adc_pkg.sv | 19 +
 rtl/adc_multi_channel_if_fifo.sv | 53 +++++
 rtl/adc_multi_channel_if.sv | 167 ++++++++++++++++
 tb/tb_adc_multi_channel_if.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and helpers for the multi-channel ADC front end.
// Mode encodings and lane packing used by the top and bench.
package adc_pkg;

  typedef enum logic [1:0] {
    ADC_MODE_PASS = 2'd0,
    ADC_MODE_AVG  = 2'd1,
    ADC_MODE_PEAK = 2'd2,
    ADC_MODE_RSVD = 2'd3
  } adc_mode_e;

  localparam int ADC_DW_DEF  = 8;
  localparam int ADC_NCH_DEF = 2;

  function automatic int lane_lo(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/adc_multi_channel_if_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr, rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = mem_q[rp_q];

  always_comb begin
    wp_d  = wr ? wp_q + 1'b1 : wp_q;
    rp_d  = rd ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wp_q] <= din;
  end

endmodule

// File: rtl/adc_multi_channel_if.sv
// Multi-channel ADC capture: clock divider, strobe, latency
// discard, per-lane pass/average/peak reduction and output FIFO.
module adc_multi_channel_if
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH   = ADC_DW_DEF,
  parameter int NCH          = ADC_NCH_DEF,
  parameter int DF_WIDTH     = 16,
  parameter int AVG_LOG2_MAX = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADC_LATENCY  = 3
) (
  input  logic                    clk_i,
  input  logic                    reset,
  input  logic [NCH*DATA_WIDTH-1:0] ADC_data,
  output logic                    ADC_oe,
  output logic                    clk_o,
  input  logic                    en,
  input  logic [DF_WIDTH-1:0]     decimation_factor,
  input  logic [1:0]              mode,
  input  logic [2:0]              win_log2,
  output logic [NCH*DATA_WIDTH-1:0] SI_data,
  output logic                    SI_rdy,
  input  logic                    SI_ack,
  output logic                    err,
  input  logic                    err_clr
);

  localparam int W   = NCH * DATA_WIDTH;
  localparam int AW  = DATA_WIDTH + AVG_LOG2_MAX;
  localparam int WCW = AVG_LOG2_MAX + 1;
  localparam int LW  = $clog2(ADC_LATENCY + 2);
  localparam logic [2:0] WL_MAX = 3'(AVG_LOG2_MAX);

  logic [DF_WIDTH-1:0] cnt_q, cnt_d;
  logic                clk_o_q, clk_o_d;
  logic                active_q, active_d;
  adc_mode_e           mode_q, mode_d;
  logic [2:0]          wl_q, wl_d;
  logic [LW-1:0]       lat_q, lat_d;
  logic [WCW-1:0]      win_q, win_d;
  logic                push_q, push_d;
  logic [W-1:0]        pdata_q, pdata_d;
  logic                err_q, err_d;

  logic           wrap, strb, valid, last;
  logic           is_avg, is_peak;
  logic [2:0]     wl_in;
  logic [WCW-1:0] win_mask;
  logic [W-1:0]   lane_res;
  logic           f_full, f_empty, f_pop;

  assign wrap     = (cnt_q == decimation_factor);
  assign strb     = wrap && clk_o_q;
  assign wl_in    = (win_log2 > WL_MAX) ? WL_MAX : win_log2;
  assign win_mask = ~({WCW{1'b1}} << wl_q);
  assign last     = (win_q == win_mask);
  assign is_avg   = (mode_q == ADC_MODE_AVG);
  assign is_peak  = (mode_q == ADC_MODE_PEAK);

  always_comb begin
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    clk_o_d  = clk_o_q ^ wrap;
    active_d = active_q;
    mode_d   = mode_q;
    wl_d     = wl_q;
    lat_d    = lat_q;
    win_d    = win_q;
    valid    = 1'b0;
    if (!en) begin
      active_d = 1'b0;
      win_d    = '0;
    end else if (strb) begin
      if (!active_q) begin
        // the starting strobe is the first discarded sample
        active_d = 1'b1;
        mode_d   = adc_mode_e'(mode);
        wl_d     = wl_in;
        win_d    = '0;
        lat_d    = LW'(ADC_LATENCY - 1);
      end else if (lat_q != '0) begin
        lat_d = lat_q - 1'b1;
      end else begin
        valid = 1'b1;
        win_d = last ? '0 : win_q + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] x, res;
    logic [AW-1:0]         acc_q, acc_d;

    assign x = ADC_data[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH];
    assign lane_res[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH] = res;

    always_comb begin
      acc_d = acc_q;
      if (valid) begin
        if (win_q == '0)           acc_d = AW'(x);
        else if (is_avg)           acc_d = acc_q + AW'(x);
        else if (AW'(x) > acc_q)   acc_d = AW'(x);
      end
      unique case (1'b1)
        is_avg:  res = DATA_WIDTH'(acc_d >> wl_q);
        is_peak: res = acc_d[DATA_WIDTH-1:0];
        default: res = x;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
    end
  end

  assign push_d  = valid && (last || (!is_avg && !is_peak));
  assign pdata_d = lane_res;
  assign f_pop   = SI_ack && !f_empty;
  assign err_d   = (push_q && f_full && !f_pop) || (err_q && !err_clr);

  always_ff @(posedge clk_i) begin
    if (reset) begin
      cnt_q    <= '0;
      clk_o_q  <= 1'b0;
      active_q <= 1'b0;
      mode_q   <= ADC_MODE_PASS;
      wl_q     <= '0;
      lat_q    <= '0;
      win_q    <= '0;
      push_q   <= 1'b0;
      pdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clk_o_q  <= clk_o_d;
      active_q <= active_d;
      mode_q   <= mode_d;
      wl_q     <= wl_d;
      lat_q    <= lat_d;
      win_q    <= win_d;
      push_q   <= push_d;
      pdata_q  <= pdata_d;
      err_q    <= err_d;
    end
  end

  sync_fifo #(
    .WIDTH(W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i(clk_i),
    .reset(reset),
    .push (push_q),
    .din  (pdata_q),
    .full (f_full),
    .pop  (f_pop),
    .dout (SI_data),
    .empty(f_empty)
  );

  assign SI_rdy = !f_empty;
  assign err    = err_q;
  assign clk_o  = clk_o_q;
  assign ADC_oe = 1'b0;

endmodule

// File: tb/tb_adc_multi_channel_if.sv
// Directed bench for adc_multi_channel_if: divider, pass, average,
// peak, overflow, config latching and reset behaviour.
module tb_adc_multi_channel_if;

  logic        clk_i = 1'b0;
  logic        reset;
  logic [15:0] ADC_data;
  logic        ADC_oe;
  logic        clk_o;
  logic        en;
  logic [15:0] decimation_factor;
  logic [1:0]  mode;
  logic [2:0]  win_log2;
  logic [15:0] SI_data;
  logic        SI_rdy;
  logic        SI_ack;
  logic        err;
  logic        err_clr;

  int errors = 0;
  int checks = 0;

  adc_multi_channel_if dut (
    .clk_i            (clk_i),
    .reset            (reset),
    .ADC_data         (ADC_data),
    .ADC_oe           (ADC_oe),
    .clk_o            (clk_o),
    .en               (en),
    .decimation_factor(decimation_factor),
    .mode             (mode),
    .win_log2         (win_log2),
    .SI_data          (SI_data),
    .SI_rdy           (SI_rdy),
    .SI_ack           (SI_ack),
    .err              (err),
    .err_clr          (err_clr)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // returns at the first negedge after clk_o has fallen
  task automatic wait_fall(input string tag);
    logic p;
    p = clk_o;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (p && !clk_o) return;
      p = clk_o;
    end
    checks++;
    errors++;
    $error("FAIL %s: clk_o fall timeout got none expected edge", tag);
  endtask

  task automatic step(input logic [15:0] d, input bit exp_push,
                      input logic [15:0] exp_w, input string tag);
    ADC_data = d;
    wait_fall(tag);
    chk({tag, ".rdy_early"}, SI_rdy, 0);
    @(negedge clk_i);
    chk({tag, ".rdy"}, SI_rdy, exp_push);
    if (exp_push) chk({tag, ".data"}, SI_data, exp_w);
  endtask

  task automatic restart(input logic [1:0] m, input logic [2:0] w);
    wait_fall("restart0");
    en = 1'b0;
    mode = m;
    win_log2 = w;
    wait_fall("restart1");
    en = 1'b1;
  endtask

  task automatic discard3(input logic [15:0] d, input string tag);
    for (int i = 0; i < 3; i++) step(d, 1'b0, 16'h0, tag);
  endtask

  initial begin
    int hi, lo;
    logic [15:0] w;
    reset = 1'b1;
    ADC_data = 16'h0;
    en = 1'b0;
    decimation_factor = 16'd2;
    mode = 2'd0;
    win_log2 = 3'd0;
    SI_ack = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(negedge clk_i);

    // 1: reset state and divider
    chk("rst.clk_o", clk_o, 0);
    chk("rst.rdy", SI_rdy, 0);
    chk("rst.err", err, 0);
    chk("rst.oe", ADC_oe, 0);
    reset = 1'b0;
    hi = 0;
    lo = 0;
    for (int n = 0; n < 50 && !clk_o; n++) @(negedge clk_i);
    for (int n = 0; n < 50 && clk_o; n++) begin
      hi++;
      @(negedge clk_i);
    end
    for (int n = 0; n < 50 && !clk_o; n++) begin
      lo++;
      @(negedge clk_i);
    end
    chk("div.high", hi, 3);
    chk("div.low", lo, 3);
    chk("div.rdy", SI_rdy, 0);

    // 2: pass-through ramp
    restart(2'd0, 3'd0);
    for (int n = 0; n < 8; n++) begin
      w = {8'(255 - n), 8'(n)};
      step(w, n >= 3, w, "ramp");
    end
    chk("ramp.err", err, 0);

    // 3: average of four
    restart(2'd1, 3'd2);
    discard3(16'hFFFF, "avg.disc");
    step(16'h010A, 1'b0, 16'h0, "avg.s0");
    step(16'h0214, 1'b0, 16'h0, "avg.s1");
    step(16'h031E, 1'b0, 16'h0, "avg.s2");
    step(16'h0429, 1'b1, 16'h0219, "avg.w0");
    step(16'hFF64, 1'b0, 16'h0, "avg.t0");
    step(16'hFF64, 1'b0, 16'h0, "avg.t1");
    step(16'hFF64, 1'b0, 16'h0, "avg.t2");
    step(16'hFF68, 1'b1, 16'hFF65, "avg.w1");

    // 4: peak over eight
    restart(2'd2, 3'd3);
    discard3(16'hFFFF, "pk.disc");
    step(16'h0A05, 1'b0, 16'h0, "pk.s0");
    step(16'hFE09, 1'b0, 16'h0, "pk.s1");
    step(16'h03C8, 1'b0, 16'h0, "pk.s2");
    step(16'h0003, 1'b0, 16'h0, "pk.s3");
    step(16'h0500, 1'b0, 16'h0, "pk.s4");
    step(16'h0701, 1'b0, 16'h0, "pk.s5");
    step(16'h0902, 1'b0, 16'h0, "pk.s6");
    step(16'h0104, 1'b1, 16'hFEC8, "pk.w0");

    // 5: overflow with ack held low
    restart(2'd0, 3'd0);
    SI_ack = 1'b0;
    discard3(16'h0000, "ov.disc");
    for (int i = 0; i < 8; i++) begin
      ADC_data = {8'(8'h80 + i), 8'(8'h10 + i)};
      wait_fall("ov.fill");
    end
    @(negedge clk_i);
    chk("ov.rdy", SI_rdy, 1);
    chk("ov.err0", err, 0);
    chk("ov.head0", SI_data, 16'h8010);
    ADC_data = 16'hDEAD;
    wait_fall("ov.ninth");
    en = 1'b0;
    @(negedge clk_i);
    chk("ov.err1", err, 1);
    chk("ov.head1", SI_data, 16'h8010);
    SI_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ov.drain_rdy", SI_rdy, 1);
      chk("ov.drain", SI_data, {8'(8'h80 + i), 8'(8'h10 + i)});
      @(negedge clk_i);
    end
    chk("ov.empty", SI_rdy, 0);
    chk("ov.err_hold", err, 1);
    err_clr = 1'b1;
    @(negedge clk_i);
    err_clr = 1'b0;
    chk("ov.err_clr", err, 0);

    // 6: config latching, en toggle, reset mid-window
    restart(2'd0, 3'd0);
    discard3(16'h0000, "cfg.disc");
    step(16'h1234, 1'b1, 16'h1234, "cfg.p0");
    mode = 2'd2;
    win_log2 = 3'd1;
    step(16'h5678, 1'b1, 16'h5678, "cfg.old");
    restart(2'd2, 3'd1);
    discard3(16'hEEEE, "cfg.disc2");
    step(16'h5030, 1'b0, 16'h0, "cfg.n0");
    step(16'h2070, 1'b1, 16'h5070, "cfg.new");
    step(16'h9999, 1'b0, 16'h0, "rst.part");
    reset = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst.mid_rdy", SI_rdy, 0);
    chk("rst.mid_err", err, 0);
    chk("rst.mid_clk", clk_o, 0);
    reset = 1'b0;
    discard3(16'hAAAA, "rst.disc");
    step(16'h0102, 1'b0, 16'h0, "rst.n0");
    step(16'h0304, 1'b1, 16'h0304, "rst.w");
    chk("end.err", err, 0);
    chk("end.oe", ADC_oe, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
